// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared sizing constants and channel state type for the button front end
package btn_debounce_pkg;

    localparam int BTN_NUM                     = 5;
    localparam int BTN_DEBOUNCE_CYCLES_DEFAULT = 1000000;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_QUAL   = 1'b1
    } ch_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: pad sync, qualification counter, level/pulse flops, sticky flag
module btn_debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DEFAULT,
    parameter logic ACTIVE_LOW      = 1'b0,
    parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    input  logic clr_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic evt_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             evt_q, evt_d;
    logic             sync_pressed;
    logic             mismatch;

    always_comb begin
        sync_pressed = sync2_q ^ ACTIVE_LOW;
        mismatch     = (sync_pressed != level_q);
        cnt_cur      = (state_q == ST_QUAL) ? cnt_q : '0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        level_d      = level_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        if (!mismatch) begin
            // a bounce back to the accepted level throws away the partial count
            state_d = ST_STABLE;
            cnt_d   = '0;
        end else if (cnt_cur == CNT_LAST) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
            level_d = sync_pressed;
            rise_d  = sync_pressed;
            fall_d  = !sync_pressed;
        end else begin
            state_d = ST_QUAL;
            cnt_d   = cnt_cur + CNT_W'(1);
        end
        // a press landing in the same cycle as a clear must survive
        evt_d = rise_d | (evt_q & ~clr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            evt_q   <= evt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign evt_o   = evt_q;

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button front end: NUM_BTN independent debounced channels
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int   NUM_BTN         = BTN_NUM,
    parameter int   DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DEFAULT,
    parameter logic ACTIVE_LOW      = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_rise,
    output logic [NUM_BTN-1:0] btn_fall,
    output logic [NUM_BTN-1:0] evt_pending,
    input  logic [NUM_BTN-1:0] evt_clr
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk_i   (clk),
            .rst_i   (rst),
            .raw_i   (btn_raw[i]),
            .clr_i   (evt_clr[i]),
            .level_o (btn_level[i]),
            .rise_o  (btn_rise[i]),
            .fall_o  (btn_fall[i]),
            .evt_o   (evt_pending[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - scoreboard bench for btn_debounce (active-high and active-low instances)
module tb_btn_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] raw_a, clr_a, lvl_a, rise_a, fall_a, evt_a;
    logic [4:0] raw_b, clr_b, lvl_b, rise_b, fall_b, evt_b;

    always #5 clk = ~clk;

    btn_debounce #(.NUM_BTN(5), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst(rst), .btn_raw(raw_a), .btn_level(lvl_a), .btn_rise(rise_a),
        .btn_fall(fall_a), .evt_pending(evt_a), .evt_clr(clr_a)
    );

    btn_debounce #(.NUM_BTN(5), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .btn_raw(raw_b), .btn_level(lvl_b), .btn_rise(rise_b),
        .btn_fall(fall_b), .evt_pending(evt_b), .evt_clr(clr_b)
    );

    typedef struct {
        int         cyc;
        logic [4:0] rise;
        logic [4:0] fall;
        logic [4:0] level;
        logic [4:0] evt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input int c, input logic [4:0] r, input logic [4:0] f,
                        input logic [4:0] l, input logic [4:0] e);
        exp_t x;
        x.cyc = c; x.rise = r; x.fall = f; x.level = l; x.evt = e;
        if (id == 0) q_a.push_back(x);
        else         q_b.push_back(x);
    endtask

    function automatic int qsize(input int id);
        return (id == 0) ? q_a.size() : q_b.size();
    endfunction

    task automatic drain(input int id, input string name);
        for (int i = 0; i < 30 && qsize(id) > 0; i++) begin
            @(negedge clk);
            #1;
        end
        check(name, qsize(id), 0);
    endtask

    // monitor: every pulse the DUT presents must match the head of its expectation queue
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (|rise_a || |fall_a)) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_pulse", {rise_a, fall_a}, 0);
            end else begin
                e = q_a.pop_front();
                check("a_cycle", cyc, e.cyc);
                check("a_rise", rise_a, e.rise);
                check("a_fall", fall_a, e.fall);
                check("a_level", lvl_a, e.level);
                check("a_evt", evt_a, e.evt);
            end
        end
        if (!rst && (|rise_b || |fall_b)) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_pulse", {rise_b, fall_b}, 0);
            end else begin
                e = q_b.pop_front();
                check("b_cycle", cyc, e.cyc);
                check("b_rise", rise_b, e.rise);
                check("b_fall", fall_b, e.fall);
                check("b_level", lvl_b, e.level);
                check("b_evt", evt_b, e.evt);
            end
        end
    end

    initial begin
        int k;
        rst   = 1'b1;
        raw_a = 5'b00000;
        clr_a = 5'b00000;
        raw_b = 5'b11111;
        clr_b = 5'b00000;
        repeat (3) @(negedge clk);
        check("rst_a_outputs", {lvl_a, rise_a, fall_a, evt_a}, 0);
        check("rst_b_outputs", {lvl_b, rise_b, fall_b, evt_b}, 0);
        rst = 1'b0;

        // 1: press btn 0, level on edge 6
        @(negedge clk);
        raw_a = 5'b00001;
        k = cyc;
        push(0, k + 6, 5'b00001, 5'b00000, 5'b00001, 5'b00001);
        repeat (5) @(negedge clk);
        #1 check("t1_level_before_edge6", lvl_a, 5'b00000);
        drain(0, "t1_press_seen");
        @(negedge clk);
        #1;
        check("t1_level_held", lvl_a, 5'b00001);
        check("t1_evt_held", evt_a, 5'b00001);
        check("t1_rise_one_cycle", rise_a, 5'b00000);
        check("t6_b_idle_level", lvl_b, 5'b00000);
        check("t6_b_idle_evt", evt_b, 5'b00000);

        // 2: bounce on btn 1 shorter than the qualification window
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            raw_a[1] = ~raw_a[1];
            @(negedge clk);
            #1 check("t2_bounce_quiet", {lvl_a[1], rise_a[1], fall_a[1], evt_a[1]}, 0);
        end
        raw_a[1] = 1'b0;
        repeat (8) @(negedge clk);
        #1 check("t2_after_bounce", {lvl_a[1], evt_a[1]}, 0);

        // 3: release btn 0, then clear its flag
        @(negedge clk);
        raw_a = 5'b00000;
        k = cyc;
        push(0, k + 6, 5'b00000, 5'b00001, 5'b00000, 5'b00001);
        drain(0, "t3_release_seen");
        repeat (3) @(negedge clk);
        #1 check("t3_evt_sticky", evt_a, 5'b00001);
        @(negedge clk);
        clr_a = 5'b00001;
        @(negedge clk);
        clr_a = 5'b00000;
        #1 check("t3_evt_cleared", evt_a, 5'b00000);

        // 4: clear held high across a press on btn 2
        @(negedge clk);
        clr_a = 5'b00100;
        raw_a = 5'b00100;
        k = cyc;
        push(0, k + 6, 5'b00100, 5'b00000, 5'b00100, 5'b00100);
        drain(0, "t4_press_seen");
        @(negedge clk);
        #1 check("t4_evt_cleared_next", evt_a, 5'b00000);
        clr_a = 5'b00000;
        raw_a = 5'b00000;
        k = cyc;
        push(0, k + 6, 5'b00000, 5'b00100, 5'b00000, 5'b00000);
        drain(0, "t4_release_seen");

        // 5: reset mid-qualification on btn 3
        @(negedge clk);
        raw_a = 5'b01000;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1 check("t5_outputs_in_rst", {lvl_a, rise_a, fall_a, evt_a}, 0);
        @(negedge clk);
        check("t5_outputs_end_rst", {lvl_a, rise_a, fall_a, evt_a}, 0);
        rst = 1'b0;
        k = cyc;
        push(0, k + 6, 5'b01000, 5'b00000, 5'b01000, 5'b01000);
        repeat (5) @(negedge clk);
        #1 check("t5_no_early_level", lvl_a, 5'b00000);
        drain(0, "t5_press_seen");

        // 6: active-low instance, press btn 0
        @(negedge clk);
        #1 check("t6_b_idle_after_rst", {lvl_b, evt_b}, 0);
        raw_b = 5'b11110;
        k = cyc;
        push(1, k + 6, 5'b00001, 5'b00000, 5'b00001, 5'b00001);
        drain(1, "t6_press_seen");
        @(negedge clk);
        #1 check("t6_b_level_held", lvl_b, 5'b00001);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
